// File: rtl/vga_rx_pkg.sv
// ---------------------------------------------------------------------------
// vga_rx_pkg
// Shared definitions for the VGA receive-side sync decoder:
//   - lock FSM state encoding
//   - default 800x600@60 (40 MHz pixel clock) timing constants and the
//     derived line/frame totals
//   - position counter width and a saturating increment helper
// ---------------------------------------------------------------------------
package vga_rx_pkg;

    // Default 800x600@60 geometry
    localparam int H_ACTIVE_DEF = 800;
    localparam int H_FP_DEF     = 40;
    localparam int H_SYNC_DEF   = 128;
    localparam int H_BP_DEF     = 88;
    localparam int V_ACTIVE_DEF = 600;
    localparam int V_FP_DEF     = 1;
    localparam int V_SYNC_DEF   = 4;
    localparam int V_BP_DEF     = 23;

    localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF; // 1056
    localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF; // 628

    // Width of the recovered position counters and x/y outputs
    localparam int POS_W = 11;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_MEASURE  = 2'd1,
        ST_LOCKED   = 2'd2
    } rx_state_e;

    // Increment that sticks at all-ones so a stream without syncs can never
    // wrap a counter back into the active window.
    function automatic logic [POS_W-1:0] sat_inc(input logic [POS_W-1:0] v);
        logic [POS_W-1:0] r;
        if (v == {POS_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + 11'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// ---------------------------------------------------------------------------
// vga_sync_edge
// Registers one raw sync line, normalises it to active-high and flags its
// leading and trailing edges (combinational from the two-deep history).
// Ports:
//   pclk   in  pixel clock
//   rst_n  in  asynchronous active-low reset
//   sync   in  raw sync line from the VGA stream
//   lead   out normalised sync went 0 -> 1 on the latest sample
//   trail  out normalised sync went 1 -> 0 on the latest sample
// Parameter POL: 1 = raw sync active-high, 0 = active-low.
// ---------------------------------------------------------------------------
module vga_sync_edge #(
    parameter bit POL = 1'b1
) (
    input  logic pclk,
    input  logic rst_n,
    input  logic sync,
    output logic lead,
    output logic trail
);

    logic sync_r;
    logic prev_r;

    // Sample the raw line (polarity-normalised) and keep one cycle of history
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            sync_r <= sync ^ ~POL;
            prev_r <= sync_r;
        end
    end

    assign lead  = sync_r & ~prev_r;
    assign trail = ~sync_r & prev_r;

endmodule

// File: rtl/vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// vga_sync_decoder
// Receive-side VGA timing recovery: rebuilds pixel coordinates and a
// data-enable from the sync edges, checks the stream against the configured
// geometry, and reports lock, error pulses and a saturating error count.
//
// Ports:
//   pclk        in   pixel clock
//   rst_n       in   asynchronous active-low reset
//   hs_in       in   horizontal sync
//   vs_in       in   vertical sync
//   rgb_in      in   12-bit {r,g,b} pixel
//   x_out       out  recovered column (valid 0..H_ACTIVE-1 while de_out)
//   y_out       out  recovered row    (valid 0..V_ACTIVE-1 while de_out)
//   de_out      out  active-video qualifier, only while locked
//   rgb_out     out  rgb_in delayed to line up with x_out/y_out/de_out
//   frame_start out  one-cycle pulse on the first active pixel (locked only)
//   locked      out  timing lock indicator
//   err         out  one-cycle pulse per timing violation
//   err_cnt     out  saturating count of err pulses
//   frame_sum   out  per-frame active-pixel checksum
//
// Optional feature macro VGA_RX_CHECKSUM_EN: when defined, frame_sum carries
// the modulo-2^16 sum of {4'b0,rgb} over each frame's active pixels; when
// undefined frame_sum is tied to 0.
//
// Pipeline: a sample taken at edge N is in the input registers after N,
// its hpos/vpos exist after N+1, and rgb/x/y/de leave the block at N+2.
// ---------------------------------------------------------------------------
module vga_sync_decoder
    import vga_rx_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int H_FP        = H_FP_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int H_BP        = H_BP_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int V_FP        = V_FP_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int V_BP        = V_BP_DEF,
    parameter bit SYNC_POL    = 1'b1,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic [11:0] rgb_in,
    output logic [10:0] x_out,
    output logic [10:0] y_out,
    output logic        de_out,
    output logic [11:0] rgb_out,
    output logic        frame_start,
    output logic        locked,
    output logic        err,
    output logic [7:0]  err_cnt,
    output logic [15:0] frame_sum
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [POS_W-1:0] H_OFS      = POS_W'(H_SYNC + H_BP);
    localparam logic [POS_W-1:0] H_LAST_ACT = POS_W'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [POS_W-1:0] V_OFS      = POS_W'(V_SYNC + V_BP);
    localparam logic [POS_W-1:0] V_LAST_ACT = POS_W'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [POS_W-1:0] H_END      = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0] H_MISS     = POS_W'(H_TOTAL);
    localparam logic [POS_W-1:0] V_END      = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0] HS_END     = POS_W'(H_SYNC - 1);
    localparam logic [POS_W-1:0] VS_END     = POS_W'(V_SYNC - 1);
    localparam logic [7:0]       LOCK_N     = 8'(LOCK_FRAMES);

    // Edge flags for the current input sample
    logic hs_lead_s, hs_trail_s, vs_lead_s, vs_trail_s;

    // Pixel data pipeline
    logic [11:0] rgb_r;
    logic [11:0] rgb_d_r;

    // Position recovery
    logic [POS_W-1:0] hpos_r;
    logic [POS_W-1:0] vpos_r;
    logic             vs_pend_r;
    logic             h_seen_r;

    // Lock FSM
    rx_state_e  state_r;
    logic [7:0] good_r;
    logic       frame_bad_r;
    logic       locked_r;
    logic       err_r;
    logic [7:0] err_cnt_r;

    // Output registers
    logic [10:0] x_r;
    logic [10:0] y_r;
    logic        de_r;
    logic [11:0] rgb_out_r;
    logic        fs_r;

    // Violation terms
    logic h_len_bad_s, h_wid_bad_s, v_len_bad_s, v_wid_bad_s, h_miss_s;
    logic checking_s, viol_s;
    logic h_act_s, v_act_s, first_px_s;

    vga_sync_edge #(.POL(SYNC_POL)) u_hs_edge (
        .pclk  (pclk),
        .rst_n (rst_n),
        .sync  (hs_in),
        .lead  (hs_lead_s),
        .trail (hs_trail_s)
    );

    vga_sync_edge #(.POL(SYNC_POL)) u_vs_edge (
        .pclk  (pclk),
        .rst_n (rst_n),
        .sync  (vs_in),
        .lead  (vs_lead_s),
        .trail (vs_trail_s)
    );

    // Pixel data: one input register plus one stage to meet the hpos/vpos stage
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_r   <= 12'd0;
            rgb_d_r <= 12'd0;
        end else begin
            rgb_r   <= rgb_in;
            rgb_d_r <= rgb_r;
        end
    end

    // Line/frame position counters recovered from the sync edges
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hpos_r    <= 11'd0;
            vpos_r    <= 11'd0;
            vs_pend_r <= 1'b0;
            h_seen_r  <= 1'b0;
        end else begin
            if (hs_lead_s) begin
                hpos_r   <= 11'd0;
                h_seen_r <= 1'b1;
                // Row 0 starts on the line carrying (or first after) the vsync edge
                if (vs_lead_s || vs_pend_r) begin
                    vpos_r <= 11'd0;
                end else begin
                    vpos_r <= sat_inc(vpos_r);
                end
                vs_pend_r <= 1'b0;
            end else begin
                hpos_r <= sat_inc(hpos_r);
                if (vs_lead_s) begin
                    vs_pend_r <= 1'b1;
                end
            end
        end
    end

    // Geometry checks; edges are tested against the counter value of the
    // previous sample, i.e. the last pixel index of the finished line/frame.
    // The very first hsync after reset has no measured line behind it.
    assign checking_s  = (state_r != ST_UNLOCKED);
    assign h_len_bad_s = hs_lead_s & h_seen_r & (hpos_r != H_END);
    assign h_wid_bad_s = hs_trail_s & (hpos_r != HS_END);
    assign v_len_bad_s = vs_lead_s & (vpos_r != V_END);
    assign v_wid_bad_s = vs_trail_s & (vpos_r != VS_END);
    assign h_miss_s    = (state_r == ST_LOCKED) & (hpos_r == H_MISS);
    assign viol_s      = checking_s &
                         (h_len_bad_s | h_wid_bad_s | v_len_bad_s | v_wid_bad_s | h_miss_s);

    // Lock FSM with error pulse and saturating error counter
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_UNLOCKED;
            good_r      <= 8'd0;
            frame_bad_r <= 1'b0;
            locked_r    <= 1'b0;
            err_r       <= 1'b0;
            err_cnt_r   <= 8'd0;
        end else begin
            err_r <= viol_s;
            if (viol_s && (err_cnt_r != 8'hFF)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end

            case (state_r)
                ST_UNLOCKED: begin
                    good_r      <= 8'd0;
                    frame_bad_r <= 1'b0;
                    locked_r    <= 1'b0;
                    if (vs_lead_s) begin
                        state_r <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    // A frame is clean only if nothing went wrong since its vsync
                    frame_bad_r <= vs_lead_s ? 1'b0 : (frame_bad_r | viol_s);
                    if (viol_s) begin
                        good_r <= 8'd0;
                    end else if (vs_lead_s) begin
                        if (frame_bad_r) begin
                            good_r <= 8'd0;
                        end else if ((good_r + 8'd1) >= LOCK_N) begin
                            good_r   <= 8'd0;
                            state_r  <= ST_LOCKED;
                            locked_r <= 1'b1;
                        end else begin
                            good_r <= good_r + 8'd1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (viol_s) begin
                        state_r  <= ST_UNLOCKED;
                        locked_r <= 1'b0;
                        good_r   <= 8'd0;
                    end
                end
                default: begin
                    state_r  <= ST_UNLOCKED;
                    locked_r <= 1'b0;
                    good_r   <= 8'd0;
                end
            endcase
        end
    end

    assign h_act_s    = (hpos_r >= H_OFS) && (hpos_r <= H_LAST_ACT);
    assign v_act_s    = (vpos_r >= V_OFS) && (vpos_r <= V_LAST_ACT);
    assign first_px_s = (hpos_r == H_OFS) && (vpos_r == V_OFS);

    // Output stage: coordinates always track, qualifiers only while locked
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            x_r       <= 11'd0;
            y_r       <= 11'd0;
            de_r      <= 1'b0;
            rgb_out_r <= 12'd0;
            fs_r      <= 1'b0;
        end else begin
            x_r       <= hpos_r - H_OFS;
            y_r       <= vpos_r - V_OFS;
            de_r      <= h_act_s & v_act_s & locked_r;
            rgb_out_r <= rgb_d_r;
            fs_r      <= first_px_s & locked_r;
        end
    end

`ifdef VGA_RX_CHECKSUM_EN
    localparam logic [10:0] X_LAST = 11'(H_ACTIVE - 1);
    localparam logic [10:0] Y_LAST = 11'(V_ACTIVE - 1);

    logic [15:0] acc_r;
    logic [15:0] frame_sum_r;
    logic [15:0] sum_next_s;

    // The first pixel of a frame restarts the sum instead of adding to it
    assign sum_next_s = fs_r ? {4'b0000, rgb_out_r} : (acc_r + {4'b0000, rgb_out_r});

    // Accumulate active pixels and publish the total after the last one
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r       <= 16'd0;
            frame_sum_r <= 16'd0;
        end else begin
            if (de_r) begin
                acc_r <= sum_next_s;
                if ((x_r == X_LAST) && (y_r == Y_LAST)) begin
                    frame_sum_r <= sum_next_s;
                end
            end
        end
    end

    assign frame_sum = frame_sum_r;
`else
    assign frame_sum = 16'd0;
`endif

    assign x_out       = x_r;
    assign y_out       = y_r;
    assign de_out      = de_r;
    assign rgb_out     = rgb_out_r;
    assign frame_start = fs_r;
    assign locked      = locked_r;
    assign err         = err_r;
    assign err_cnt     = err_cnt_r;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_decoder
// Directed bench for vga_sync_decoder on a reduced geometry (16 x 9 total,
// 8 x 4 active) so that many frames fit in a short run. Inputs change on the
// falling clock edge; outputs are sampled on the falling edge just before.
// ---------------------------------------------------------------------------
module tb_vga_sync_decoder;

    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 3;
    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int HT = HA + HF + HS + HB; // 16
    localparam int VT = VA + VF + VS + VB; // 9

`ifdef VGA_RX_CHECKSUM_EN
    // sum over x=0..7, y=0..3 of x*256 + y*16 + 5
    localparam int SUM_PAT = 29600;
    localparam int SUM_ONE = 32;
`else
    localparam int SUM_PAT = 0;
    localparam int SUM_ONE = 0;
`endif

    logic        pclk = 1'b0;
    logic        rst_n;
    logic        hs_in;
    logic        vs_in;
    logic [11:0] rgb_in;
    logic [10:0] x_out;
    logic [10:0] y_out;
    logic        de_out;
    logic [11:0] rgb_out;
    logic        frame_start;
    logic        locked;
    logic        err;
    logic [7:0]  err_cnt;
    logic [15:0] frame_sum;

    int total = 0;
    int bad   = 0;

    int de_cnt;
    int fs_cnt;
    int err_seen;
    bit mon_rgb;
    bit miss_mode;
    bit seen_de;

    vga_sync_decoder #(
        .H_ACTIVE    (HA),
        .H_FP        (HF),
        .H_SYNC      (HS),
        .H_BP        (HB),
        .V_ACTIVE    (VA),
        .V_FP        (VF),
        .V_SYNC      (VS),
        .V_BP        (VB),
        .SYNC_POL    (1'b1),
        .LOCK_FRAMES (2)
    ) dut (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .hs_in       (hs_in),
        .vs_in       (vs_in),
        .rgb_in      (rgb_in),
        .x_out       (x_out),
        .y_out       (y_out),
        .de_out      (de_out),
        .rgb_out     (rgb_out),
        .frame_start (frame_start),
        .locked      (locked),
        .err         (err),
        .err_cnt     (err_cnt),
        .frame_sum   (frame_sum)
    );

    // 40 MHz-style free-running pixel clock
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic monitor();
        if (err === 1'b1) begin
            err_seen++;
            // missing hsync is flagged when hpos reaches H_TOTAL -> x = 16 - 6
            if (miss_mode) chk("miss_x", 32'(x_out), 32'd10);
        end
        if (frame_start === 1'b1) begin
            fs_cnt++;
            chk("fs_xy", 32'({x_out, y_out}), 32'd0);
        end
        if (de_out === 1'b1) begin
            de_cnt++;
            if (mon_rgb) chk("rgb_align", 32'(rgb_out), 32'({x_out[3:0], y_out[3:0], 4'h5}));
            if (!seen_de) begin
                chk("fs_first", 32'(frame_start), 32'd1);
                seen_de = 1'b1;
            end
        end
    endtask

    task automatic pix(input bit h, input bit v, input logic [11:0] c);
        @(negedge pclk);
        monitor();
        hs_in  = h;
        vs_in  = v;
        rgb_in = c;
    endtask

    // mode: 0 normal, 1 line 1 one pclk short, 2 no hsync on line 2,
    //       3 constant rgb 12'h001, 4 reset pulse in the middle of line 5
    task automatic run_frame(input int mode);
        seen_de = 1'b0;
        de_cnt  = 0;
        fs_cnt  = 0;
        for (int v = 0; v < VT; v++) begin
            int len;
            len = (mode == 1 && v == 1) ? HT - 1 : HT;
            for (int h = 0; h < len; h++) begin
                bit          hb;
                logic [3:0]  xx;
                logic [3:0]  yy;
                logic [11:0] c;
                hb = (h < HS) && !(mode == 2 && v == 2);
                xx = 4'(h - (HS + HB));
                yy = 4'(v - (VS + VB));
                c  = (mode == 3) ? 12'h001 : {xx, yy, 4'h5};
                pix(hb, (v < VS), c);
                if (mode == 4 && v == 5 && h == 8) begin
                    chk("pre_rst_lock", 32'(locked), 32'd1);
                    rst_n = 1'b0;
                    #1;
                    chk("mid_rst_locked", 32'(locked), 32'd0);
                    chk("mid_rst_errcnt", 32'(err_cnt), 32'd0);
                    chk("mid_rst_x", 32'(x_out), 32'd0);
                    chk("mid_rst_y", 32'(y_out), 32'd0);
                    chk("mid_rst_rgb", 32'(rgb_out), 32'd0);
                    chk("mid_rst_de", 32'(de_out), 32'd0);
                end
                if (mode == 4 && v == 5 && h == 11) rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        hs_in     = 1'b0;
        vs_in     = 1'b0;
        rgb_in    = 12'd0;
        mon_rgb   = 1'b0;
        miss_mode = 1'b0;
        seen_de   = 1'b0;
        err_seen  = 0;
        de_cnt    = 0;
        fs_cnt    = 0;

        repeat (3) @(negedge pclk);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_de", 32'(de_out), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_errcnt", 32'(err_cnt), 32'd0);
        chk("rst_xy", 32'({x_out, y_out}), 32'd0);
        chk("rst_rgb", 32'(rgb_out), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_sum", 32'(frame_sum), 32'd0);
        @(negedge pclk);
        rst_n = 1'b1;

        // frames 0,1: MEASURE entry plus first clean frame
        run_frame(0);
        run_frame(0);
        chk("lock_early", 32'(locked), 32'd0);

        // frame 2: locked from its vsync, data path checked
        mon_rgb = 1'b1;
        run_frame(0);
        chk("lock_up", 32'(locked), 32'd1);
        chk("errcnt_clean", 32'(err_cnt), 32'd0);
        chk("de_count", 32'(de_cnt), 32'(HA * VA));
        chk("fs_count", 32'(fs_cnt), 32'd1);
        chk("sum_pattern", 32'(frame_sum), 32'(SUM_PAT));

        // frame 3: one short line
        run_frame(1);
        chk("short_unlock", 32'(locked), 32'd0);
        chk("short_errcnt", 32'(err_cnt), 32'd1);
        chk("short_pulses", 32'(err_seen), 32'd1);
        chk("short_no_de", 32'(de_cnt), 32'd0);

        // frames 4..6: relock needs the entry vsync plus two clean frames
        run_frame(0);
        run_frame(0);
        chk("relock_early", 32'(locked), 32'd0);
        run_frame(0);
        chk("relock", 32'(locked), 32'd1);
        chk("relock_errcnt", 32'(err_cnt), 32'd1);

        // frame 7: hsync pulse missing on one line
        miss_mode = 1'b1;
        run_frame(2);
        miss_mode = 1'b0;
        chk("miss_unlock", 32'(locked), 32'd0);
        chk("miss_errcnt", 32'(err_cnt), 32'd2);
        chk("miss_pulses", 32'(err_seen), 32'd2);

        // frames 8,9 relock, frame 10 locked then reset mid-frame
        run_frame(0);
        run_frame(0);
        run_frame(4);

        // frames 11..13: full vsync-to-vsync pass again after reset
        run_frame(0);
        run_frame(0);
        chk("rst_relock_early", 32'(locked), 32'd0);
        run_frame(0);
        chk("rst_relock", 32'(locked), 32'd1);
        chk("rst_relock_errcnt", 32'(err_cnt), 32'd0);

        // frame 14: constant pixel value for the checksum
        mon_rgb = 1'b0;
        run_frame(3);
        chk("sum_const", 32'(frame_sum), 32'(SUM_ONE));
        chk("const_de_count", 32'(de_cnt), 32'(HA * VA));
        chk("final_pulses", 32'(err_seen), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
